// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only link between the integrity checker and the system ID slave.
interface sysid_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );
endinterface

// File: rtl/sysid_checker.sv
// Boot-time check of the system ID peripheral: reads ID (word 0) and build
// timestamp (word 1), compares them with build-time constants, reports the result.
//
// state      | meaning
// IDLE       | waiting for start (or the automatic post-reset start)
// RD_ID_REQ  | read of word 0 presented, held until waitrequest drops
// RD_ID_WAIT | read of word 0 accepted, waiting for readdatavalid
// RD_TS_REQ  | read of word 1 presented, held until waitrequest drops
// RD_TS_WAIT | read of word 1 accepted, waiting for readdatavalid
// COMPARE    | evaluate captured words against expected values
// DONE       | one-cycle done pulse; otherwise behaves as IDLE
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h0000_0000,
    parameter bit          CHECK_TIMESTAMP    = 1'b1,
    parameter bit          AUTO_START         = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter int unsigned RETRIES            = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    sysid_checker_if.master        bus,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   fail,
    output logic                   id_ok,
    output logic                   ts_ok,
    output logic                   timeout,
    output logic [31:0]            read_id,
    output logic [31:0]            read_ts
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ID_REQ,
        RD_ID_WAIT,
        RD_TS_REQ,
        RD_TS_WAIT,
        COMPARE,
        DONE
    } state_t;

    localparam logic [15:0] TC_LAST   = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(RETRIES);

    state_t      state, state_next;
    logic [15:0] tcount, tcount_next;
    logic [3:0]  retry, retry_next;
    logic        auto_pending;
    logic        rd, rd_next;
    logic        addr, addr_next;
    logic        busy_next, done_next, pass_next, fail_next;
    logic        id_ok_next, ts_ok_next, timeout_next;
    logic [31:0] read_id_next, read_ts_next;
    logic        go, in_req, in_wait, accept, got, expired;

    assign bus.avm_read    = rd;
    assign bus.avm_address = addr;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            tcount       <= '0;
            retry        <= '0;
            auto_pending <= AUTO_START;
            rd           <= 1'b0;
            addr         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            id_ok        <= 1'b0;
            ts_ok        <= 1'b0;
            timeout      <= 1'b0;
            read_id      <= '0;
            read_ts      <= '0;
        end else begin
            state        <= state_next;
            tcount       <= tcount_next;
            retry        <= retry_next;
            auto_pending <= 1'b0;
            rd           <= rd_next;
            addr         <= addr_next;
            busy         <= busy_next;
            done         <= done_next;
            pass         <= pass_next;
            fail         <= fail_next;
            id_ok        <= id_ok_next;
            ts_ok        <= ts_ok_next;
            timeout      <= timeout_next;
            read_id      <= read_id_next;
            read_ts      <= read_ts_next;
        end
    end

    always_comb begin
        in_req  = (state == RD_ID_REQ) || (state == RD_TS_REQ);
        in_wait = (state == RD_ID_WAIT) || (state == RD_TS_WAIT);
        go      = start || auto_pending;
        accept  = in_req && rd && !bus.avm_waitrequest;
        got     = in_wait && bus.avm_readdatavalid;
        // A read that completes on its last budgeted cycle is not abandoned.
        expired = (in_req || in_wait) && (tcount == TC_LAST) && !accept && !got;

        state_next   = state;
        tcount_next  = tcount;
        retry_next   = retry;
        pass_next    = pass;
        fail_next    = fail;
        id_ok_next   = id_ok;
        ts_ok_next   = ts_ok;
        timeout_next = timeout;
        read_id_next = read_id;
        read_ts_next = read_ts;

        if (in_req || in_wait) begin
            tcount_next = tcount + 16'd1;
        end

        case (state)
            IDLE, DONE: begin
                if (go) begin
                    state_next   = RD_ID_REQ;
                    tcount_next  = '0;
                    retry_next   = '0;
                    pass_next    = 1'b0;
                    fail_next    = 1'b0;
                    id_ok_next   = 1'b0;
                    ts_ok_next   = 1'b0;
                    timeout_next = 1'b0;
                end else begin
                    state_next = IDLE;
                end
            end
            RD_ID_REQ: begin
                if (accept) state_next = RD_ID_WAIT;
            end
            RD_ID_WAIT: begin
                if (got) begin
                    read_id_next = bus.avm_readdata;
                    state_next   = RD_TS_REQ;
                    tcount_next  = '0;
                end
            end
            RD_TS_REQ: begin
                if (accept) state_next = RD_TS_WAIT;
            end
            RD_TS_WAIT: begin
                if (got) begin
                    read_ts_next = bus.avm_readdata;
                    state_next   = COMPARE;
                end
            end
            COMPARE: begin
                id_ok_next = (read_id == EXPECTED_ID);
                ts_ok_next = (read_ts == EXPECTED_TIMESTAMP);
                pass_next  = id_ok_next && (ts_ok_next || !CHECK_TIMESTAMP);
                fail_next  = !pass_next;
                state_next = DONE;
            end
            default: state_next = IDLE;
        endcase

        // A timed-out read restarts the whole sequence until retries run out.
        if (expired) begin
            tcount_next = '0;
            if (retry < RETRY_MAX) begin
                retry_next = retry + 4'd1;
                state_next = RD_ID_REQ;
            end else begin
                timeout_next = 1'b1;
                fail_next    = 1'b1;
                pass_next    = 1'b0;
                state_next   = DONE;
            end
        end

        rd_next   = (state_next == RD_ID_REQ) || (state_next == RD_TS_REQ);
        addr_next = (state_next == RD_TS_REQ) || (state_next == RD_TS_WAIT);
        busy_next = (state_next != IDLE) && (state_next != DONE);
        done_next = (state_next == DONE);
    end

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: a scripted Avalon slave with per-word stall/latency,
// a cycle-budget reference model, and directed plus randomized checks.
`timescale 1ns/1ps
module tb_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'h547C_F79F;
    localparam logic [31:0] BAD_TS = 32'h547C_D9DF;
    localparam int TMO = 8;
    localparam int RTY = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy, done, pass, fail, id_ok, ts_ok, timeout;
    logic [31:0] read_id, read_ts;
    logic busy2, done2, pass2, fail2, id_ok2, ts_ok2, timeout2;
    logic [31:0] read_id2, read_ts2;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int id_attempts = 0;
    logic prev_rd = 1'b0;

    int wait_n [2];
    int lat_n [2];
    logic [31:0] sdata [2];
    bit respond = 1'b1;

    int pend = 0;
    int stalls = 0;
    int acc_addr = 0;
    bit was_stall = 1'b0;
    logic prev_addr = 1'b0;

    sysid_checker_if bus ();
    sysid_checker_if bus2 ();

    assign bus2.avm_waitrequest   = bus.avm_waitrequest;
    assign bus2.avm_readdata      = bus.avm_readdata;
    assign bus2.avm_readdatavalid = bus.avm_readdatavalid;

    sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS), .CHECK_TIMESTAMP(1'b1),
        .AUTO_START(1'b1), .TIMEOUT_CYCLES(TMO), .RETRIES(RTY)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .bus(bus),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .id_ok(id_ok),
        .ts_ok(ts_ok), .timeout(timeout), .read_id(read_id), .read_ts(read_ts)
    );

    // Twin with the timestamp reported only; it sees the same slave responses.
    sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS), .CHECK_TIMESTAMP(1'b0),
        .AUTO_START(1'b1), .TIMEOUT_CYCLES(TMO), .RETRIES(RTY)
    ) dut_nc (
        .clock(clock), .reset(reset), .start(start), .bus(bus2),
        .busy(busy2), .done(done2), .pass(pass2), .fail(fail2), .id_ok(id_ok2),
        .ts_ok(ts_ok2), .timeout(timeout2), .read_id(read_id2), .read_ts(read_ts2)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc = cyc + 1;
    end

    task automatic check1(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Slave: per-word stall count before accepting, then readdatavalid lat cycles later.
    initial begin
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdata      = '0;
        bus.avm_readdatavalid = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            bus.avm_readdatavalid = 1'b0;
            if (reset) begin
                pend = 0;
                stalls = 0;
                was_stall = 1'b0;
                bus.avm_waitrequest = 1'b0;
            end else begin
                if (was_stall) begin
                    total++;
                    assert (bus.avm_read === 1'b1 && bus.avm_address === prev_addr) else begin
                        bad++;
                        $error("FAIL stall_hold: observed read=%b addr=%b expected read=1 addr=%b",
                               bus.avm_read, bus.avm_address, prev_addr);
                    end
                end
                if (pend > 0) begin
                    pend--;
                    if (pend == 0 && respond) begin
                        bus.avm_readdatavalid = 1'b1;
                        bus.avm_readdata = sdata[acc_addr];
                    end
                end
                was_stall = 1'b0;
                if (bus.avm_read === 1'b1) begin
                    acc_addr = bus.avm_address ? 1 : 0;
                    if (stalls < wait_n[acc_addr]) begin
                        stalls++;
                        bus.avm_waitrequest = 1'b1;
                        was_stall = 1'b1;
                        prev_addr = bus.avm_address;
                    end else begin
                        bus.avm_waitrequest = 1'b0;
                        stalls = 0;
                        pend = lat_n[acc_addr];
                    end
                end else begin
                    bus.avm_waitrequest = 1'b0;
                end
            end
        end
    end

    initial forever begin
        @(posedge clock);
        #1;
        if (done === 1'b1) done_cnt++;
        if (bus.avm_read === 1'b1 && prev_rd !== 1'b1 && bus.avm_address === 1'b0)
            id_attempts++;
        prev_rd = bus.avm_read;
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic set_slave(input int wid, input int lid, input int wts, input int lts,
                             input logic [31:0] rid, input logic [31:0] rts, input bit resp);
        wait_n[0] = wid; lat_n[0] = lid; sdata[0] = rid;
        wait_n[1] = wts; lat_n[1] = lts; sdata[1] = rts;
        respond = resp;
    endtask

    // Each read owns a budget of TMO cycles (REQ cycles plus WAIT cycles); a read that
    // cannot finish within it fails every attempt, so the check ends in timeout.
    function automatic int model_offset(input int wid, input int lid, input int wts,
                                        input int lts, input bit resp, output bit to);
        int len_id;
        int len_ts;
        len_id = wid + lid + 1;
        len_ts = wts + lts + 1;
        if (!resp || len_id > TMO) begin
            to = 1'b1;
            return 1 + (RTY + 1) * TMO;
        end
        if (len_ts > TMO) begin
            to = 1'b1;
            return 1 + (RTY + 1) * (len_id + TMO);
        end
        to = 1'b0;
        return 1 + len_id + len_ts + 1;
    endfunction

    task automatic finish_check(input string tag, input int t0, input int wid, input int lid,
                                input int wts, input int lts, input logic [31:0] rid,
                                input logic [31:0] rts, input bit resp, input int dc0, input int ia0);
        int n;
        int off;
        bit to;
        bit idm;
        bit tsm;
        off = model_offset(wid, lid, wts, lts, resp, to);
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        idm = !to && (rid == EXP_ID);
        tsm = !to && (rts == EXP_TS);
        check1({tag, ".done"}, done, 1'b1);
        check1({tag, ".done_nc"}, done2, 1'b1);
        check32({tag, ".cycle"}, cyc - t0, off);
        check32({tag, ".ndone"}, done_cnt - dc0, 1);
        check32({tag, ".attempts"}, id_attempts - ia0, to ? RTY + 1 : 1);
        check1({tag, ".busy"}, busy, 1'b0);
        check1({tag, ".timeout"}, timeout, to);
        check1({tag, ".pass"}, pass, idm && tsm);
        check1({tag, ".fail"}, fail, !(idm && tsm));
        check1({tag, ".id_ok"}, id_ok, idm);
        check1({tag, ".ts_ok"}, ts_ok, tsm);
        check1({tag, ".pass_nc"}, pass2, idm);
        check1({tag, ".fail_nc"}, fail2, !idm);
        check1({tag, ".ts_ok_nc"}, ts_ok2, tsm);
        if (!to) begin
            check32({tag, ".read_id"}, read_id, rid);
            check32({tag, ".read_ts"}, read_ts, rts);
        end
    endtask

    task automatic run(input string tag, input int wid, input int lid, input int wts,
                       input int lts, input logic [31:0] rid, input logic [31:0] rts, input bit resp);
        int t0;
        int dc0;
        int ia0;
        set_slave(wid, lid, wts, lts, rid, rts, resp);
        dc0 = done_cnt;
        ia0 = id_attempts;
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        finish_check(tag, t0, wid, lid, wts, lts, rid, rts, resp, dc0, ia0);
    endtask

    initial begin
        int t0, dc0, ia0;
        int wid, lid, wts, lts;
        logic [31:0] rid, rts;

        set_slave(0, 1, 0, 1, EXP_ID, EXP_TS, 1'b1);
        repeat (3) tick();
        check1("rst.busy", busy, 1'b0);
        check1("rst.done", done, 1'b0);
        check1("rst.pass", pass, 1'b0);
        check1("rst.fail", fail, 1'b0);
        check1("rst.timeout", timeout, 1'b0);
        check1("rst.read", bus.avm_read, 1'b0);
        check32("rst.read_id", read_id, 32'h0);
        check32("rst.read_ts", read_ts, 32'h0);

        // automatic check after reset release, nominal slave
        reset = 1'b0;
        t0 = cyc;
        dc0 = done_cnt;
        ia0 = id_attempts;
        tick();
        check1("auto.read", bus.avm_read, 1'b1);
        check1("auto.addr", bus.avm_address, 1'b0);
        check1("auto.busy", busy, 1'b1);
        finish_check("auto", t0, 0, 1, 0, 1, EXP_ID, EXP_TS, 1'b1, dc0, ia0);
        tick();
        check1("after.done", done, 1'b0);
        check1("after.pass_sticky", pass, 1'b1);

        run("ts_mismatch", 0, 1, 0, 1, EXP_ID, BAD_TS, 1'b1);
        run("stall", 3, 2, 3, 2, EXP_ID, EXP_TS, 1'b1);
        run("edge_fit", 4, 3, 0, 1, EXP_ID, EXP_TS, 1'b1);
        run("edge_over", 4, 4, 0, 1, EXP_ID, EXP_TS, 1'b1);
        run("ts_over", 0, 1, 4, 4, EXP_ID, EXP_TS, 1'b1);
        run("no_resp", 0, 1, 0, 1, EXP_ID, EXP_TS, 1'b0);

        // start in the DONE cycle restarts with cleared flags
        set_slave(0, 1, 0, 1, EXP_ID, EXP_TS, 1'b1);
        dc0 = done_cnt;
        ia0 = id_attempts;
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        check1("redo.busy", busy, 1'b1);
        check1("redo.fail_clr", fail, 1'b0);
        check1("redo.timeout_clr", timeout, 1'b0);
        check1("redo.read", bus.avm_read, 1'b1);
        finish_check("redo", t0, 0, 1, 0, 1, EXP_ID, EXP_TS, 1'b1, dc0, ia0);

        // start in cycle 3 of a running check is ignored
        dc0 = done_cnt;
        ia0 = id_attempts;
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_check("busy_start", t0, 0, 1, 0, 1, EXP_ID, EXP_TS, 1'b1, dc0, ia0);
        repeat (10) tick();
        check32("busy_start.ndone_late", done_cnt - dc0, 1);

        // reset during the timestamp wait
        set_slave(0, 1, 0, 4, EXP_ID, EXP_TS, 1'b1);
        dc0 = done_cnt;
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check1("abort.busy", busy, 1'b0);
        check1("abort.read", bus.avm_read, 1'b0);
        check1("abort.done", done, 1'b0);
        check1("abort.pass", pass, 1'b0);
        check32("abort.read_ts", read_ts, 32'h0);
        reset = 1'b0;
        t0 = cyc;
        ia0 = id_attempts;
        tick();
        check1("abort.auto_read", bus.avm_read, 1'b1);
        check1("abort.auto_addr", bus.avm_address, 1'b0);
        check32("abort.no_done", done_cnt - dc0, 0);
        finish_check("abort", t0, 0, 1, 0, 4, EXP_ID, EXP_TS, 1'b1, dc0, ia0);

        for (int i = 0; i < 12; i++) begin
            wid = int'($urandom_range(0, 4));
            lid = int'($urandom_range(1, 4));
            wts = int'($urandom_range(0, 4));
            lts = int'($urandom_range(1, 4));
            rid = ($urandom_range(0, 2) != 0) ? EXP_ID : $urandom();
            rts = ($urandom_range(0, 2) != 0) ? EXP_TS : $urandom();
            tick();
            run($sformatf("rand%0d", i), wid, lid, wts, lts, rid, rts, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
